// File: rtl/id_stage_pipeline_pkg.sv
// Shared decode constants, FSM states and opcode control decode
// for the ID stage.
package id_stage_pipeline_pkg;

  localparam int DATA_LEN     = 32;
  localparam int REG_ADDR_LEN = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_e;

  typedef struct packed {
    logic we;
    logic dest_rd;
    logic use_rs;
    logic use_rt;
    logic is_load;
    logic is_store;
  } ctl_t;

  function automatic ctl_t decode(input logic [5:0] op);
    ctl_t c;
    c = '0;
    unique case (op)
      OP_RTYPE: begin
        c.we      = 1'b1;
        c.dest_rd = 1'b1;
        c.use_rs  = 1'b1;
        c.use_rt  = 1'b1;
      end
      OP_LW: begin
        c.we      = 1'b1;
        c.use_rs  = 1'b1;
        c.is_load = 1'b1;
      end
      OP_SW: begin
        c.use_rs   = 1'b1;
        c.use_rt   = 1'b1;
        c.is_store = 1'b1;
      end
      OP_BEQ: begin
        c.use_rs = 1'b1;
        c.use_rt = 1'b1;
      end
      OP_ADDI, OP_ORI: begin
        c.we     = 1'b1;
        c.use_rs = 1'b1;
      end
      OP_LUI: c.we = 1'b1;
      OP_J:   c = '0;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_pipeline_fwd_mux.sv
// Per-operand forwarding selector: EX, then MEM, then WB,
// then register file; register 0 always reads as zero.
module id_fwd_mux #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] src_i,
  input  logic [DATA_W-1:0]  rf_data_i,
  input  logic               ex_en_i,
  input  logic [RADDR_W-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0]  ex_data_i,
  input  logic               mem_we_i,
  input  logic [RADDR_W-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0]  mem_wdata_i,
  input  logic               wb_we_i,
  input  logic [RADDR_W-1:0] wb_waddr_i,
  input  logic [DATA_W-1:0]  wb_wdata_i,
  output logic [DATA_W-1:0]  data_o
);

  always_comb begin
    data_o = rf_data_i;
    if (src_i == '0) begin
      data_o = '0;
    end else if (ex_en_i && ex_waddr_i == src_i) begin
      data_o = ex_data_i;
    end else if (mem_we_i && mem_waddr_i == src_i) begin
      data_o = mem_wdata_i;
    end else if (wb_we_i && wb_waddr_i == src_i) begin
      data_o = wb_wdata_i;
    end
  end

endmodule

// File: rtl/id_stage_pipeline.sv
// ID stage: decode, operand forwarding, load-use stall and ID/EX register.
// Optional stall counter port enabled by ID_STALL_CNT_EN.
module id_stage_pipeline
  import id_stage_pipeline_pkg::*;
#(
  parameter int DATA_W  = DATA_LEN,
  parameter int RADDR_W = REG_ADDR_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_id_valid,
  input  logic [31:0]        if_id_inst,
  input  logic [DATA_W-1:0]  if_id_pc,
  output logic [RADDR_W-1:0] rf_raddr1,
  output logic [RADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0]  rf_rdata1,
  input  logic [DATA_W-1:0]  rf_rdata2,
  input  logic [DATA_W-1:0]  ex_alu_res,
  input  logic               mem_we,
  input  logic [RADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0]  wb_wdata,
  input  logic               ex_flush,
  output logic               stall_if,
  output logic               id_ex_valid,
  output logic [DATA_W-1:0]  id_ex_pc,
  output logic [5:0]         id_ex_op,
  output logic [5:0]         id_ex_funct,
  output logic [DATA_W-1:0]  id_ex_a,
  output logic [DATA_W-1:0]  id_ex_b,
  output logic [DATA_W-1:0]  id_ex_imm,
  output logic [RADDR_W-1:0] id_ex_waddr,
  output logic               id_ex_we,
  output logic               id_ex_is_load,
  output logic               id_ex_is_store
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  logic [5:0]         op;
  logic [RADDR_W-1:0] rs, rt, rd, dest;
  logic [DATA_W-1:0]  imm_x, opa, opb;
  ctl_t               ctl;
  logic               ex_fwd, load_use, hazard;
  state_e             state_q, state_d;

  logic               valid_q, valid_d, we_q, we_d;
  logic               ld_q, ld_d, st_q, st_d;
  logic [DATA_W-1:0]  pc_q, pc_d, a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]  imm_q, imm_d;
  logic [5:0]         op_q, op_d, funct_q, funct_d;
  logic [RADDR_W-1:0] waddr_q, waddr_d;

  assign op   = if_id_inst[31:26];
  assign rs   = RADDR_W'(if_id_inst[25:21]);
  assign rt   = RADDR_W'(if_id_inst[20:16]);
  assign rd   = RADDR_W'(if_id_inst[15:11]);
  assign ctl  = decode(op);
  assign dest = ctl.dest_rd ? rd : rt;

  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  always_comb begin
    imm_x = DATA_W'(signed'(if_id_inst[15:0]));
    unique case (1'b1)
      (op == OP_ORI): imm_x = DATA_W'(if_id_inst[15:0]);
      (op == OP_LUI): imm_x = DATA_W'({if_id_inst[15:0], 16'h0000});
      default:        imm_x = DATA_W'(signed'(if_id_inst[15:0]));
    endcase
  end

  // A load in EX has no result yet, so it never forwards from EX
  assign ex_fwd = valid_q && we_q && !ld_q;

  id_fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_a (
    .src_i      (rs),
    .rf_data_i  (rf_rdata1),
    .ex_en_i    (ex_fwd),
    .ex_waddr_i (waddr_q),
    .ex_data_i  (ex_alu_res),
    .mem_we_i   (mem_we),
    .mem_waddr_i(mem_waddr),
    .mem_wdata_i(mem_wdata),
    .wb_we_i    (wb_we),
    .wb_waddr_i (wb_waddr),
    .wb_wdata_i (wb_wdata),
    .data_o     (opa)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_b (
    .src_i      (rt),
    .rf_data_i  (rf_rdata2),
    .ex_en_i    (ex_fwd),
    .ex_waddr_i (waddr_q),
    .ex_data_i  (ex_alu_res),
    .mem_we_i   (mem_we),
    .mem_waddr_i(mem_waddr),
    .mem_wdata_i(mem_wdata),
    .wb_we_i    (wb_we),
    .wb_waddr_i (wb_waddr),
    .wb_wdata_i (wb_wdata),
    .data_o     (opb)
  );

  assign load_use = valid_q && ld_q && (waddr_q != '0) && if_id_valid
                 && ((ctl.use_rs && waddr_q == rs)
                  || (ctl.use_rt && waddr_q == rt));
  assign hazard   = (state_q == RUN) && load_use;
  assign stall_if = hazard && !ex_flush;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (hazard) state_d = BUBBLE;
      BUBBLE:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    valid_d = if_id_valid;
    pc_d    = if_id_pc;
    op_d    = op;
    funct_d = if_id_inst[5:0];
    a_d     = opa;
    b_d     = opb;
    imm_d   = imm_x;
    waddr_d = ctl.we ? dest : '0;
    we_d    = ctl.we && (dest != '0);
    ld_d    = ctl.is_load;
    st_d    = ctl.is_store;
    // Flush and bubble both leave an empty slot in EX
    if (ex_flush || hazard) begin
      valid_d = 1'b0;
      pc_d    = '0;
      op_d    = '0;
      funct_d = '0;
      a_d     = '0;
      b_d     = '0;
      imm_d   = '0;
      waddr_d = '0;
      we_d    = 1'b0;
      ld_d    = 1'b0;
      st_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      pc_q    <= '0;
      op_q    <= '0;
      funct_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
    end
  end

  assign id_ex_valid    = valid_q;
  assign id_ex_pc       = pc_q;
  assign id_ex_op       = op_q;
  assign id_ex_funct    = funct_q;
  assign id_ex_a        = a_q;
  assign id_ex_b        = b_q;
  assign id_ex_imm      = imm_q;
  assign id_ex_waddr    = waddr_q;
  assign id_ex_we       = we_q;
  assign id_ex_is_load  = ld_q;
  assign id_ex_is_store = st_q;

`ifdef ID_STALL_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (stall_if) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign stall_cnt = cnt_q;
`endif

endmodule
